// File: rtl/multi_debouncer_pkg.sv
// Shared types and elaboration helpers for the multi-channel debouncer.
// The optional long-press logic is enabled by MULTI_DEBOUNCER_LONG_PRESS_EN.
package multi_debouncer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE_LO = 2'd0,
      ST_WAIT_HI = 2'd1,
      ST_IDLE_HI = 2'd2,
      ST_WAIT_LO = 2'd3
   } state_e;

   // The stability counter must hold STABLE_CNT-1 without wrapping.
   function automatic bit cnt_w_ok(input int cnt_w, input int stable_cnt);
      return (stable_cnt >= 2) && (cnt_w >= 1) && (cnt_w < 31) && ((1 << cnt_w) > stable_cnt);
   endfunction

endpackage

// File: rtl/multi_debouncer_channel.sv
// One debounced channel: 2-flop synchroniser, 4-state FSM and stability counter.
// With MULTI_DEBOUNCER_LONG_PRESS_EN defined, a saturating hold counter drives hold_o.
module debounce_channel
   import multi_debouncer_pkg::*;
#(
   parameter int STABLE_CNT = 16,
   parameter int CNT_W      = 5,
   parameter int LONG_CNT   = 1000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tick_i,
   input  logic       in_i,
   output logic       out_o,
   output logic       rise_o,
   output logic       fall_o,
   output logic [1:0] state_o,
   output logic       hold_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   if (LONG_CNT < 1) begin : g_bad_long_cnt
      $error("LONG_CNT must be at least 1");
   end

   logic [1:0]       sync_q;
   logic             s;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             out_q;
   logic             rise_q;
   logic             fall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], in_i};
      end
   end

   assign s = sync_q[1];

   // A WAIT state is aborted by the first disagreeing sample, so cnt_q never passes CNT_LAST.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE_LO;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         if (tick_i) begin
            case (state_q)
               ST_IDLE_LO: begin
                  if (s) begin
                     state_q <= ST_WAIT_HI;
                     cnt_q   <= CNT_W'(1);
                  end
               end
               ST_WAIT_HI: begin
                  if (!s) begin
                     state_q <= ST_IDLE_LO;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= ST_IDLE_HI;
                     cnt_q   <= '0;
                     out_q   <= 1'b1;
                     rise_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               ST_IDLE_HI: begin
                  if (!s) begin
                     state_q <= ST_WAIT_LO;
                     cnt_q   <= CNT_W'(1);
                  end
               end
               ST_WAIT_LO: begin
                  if (s) begin
                     state_q <= ST_IDLE_HI;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= ST_IDLE_LO;
                     cnt_q   <= '0;
                     out_q   <= 1'b0;
                     fall_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               default: begin
                  state_q <= ST_IDLE_LO;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign out_o   = out_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign state_o = state_q;

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
   localparam int HOLD_W = $clog2(LONG_CNT + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CNT);

   logic [HOLD_W-1:0] hold_cnt_q;

   // Clears on the same edge the FSM leaves IDLE_HI.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_cnt_q <= '0;
      end else if ((state_q != ST_IDLE_HI) || (tick_i && !s)) begin
         hold_cnt_q <= '0;
      end else if (tick_i && (hold_cnt_q != HOLD_MAX)) begin
         hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
      end
   end

   assign hold_o = (hold_cnt_q == HOLD_MAX);
`else
   assign hold_o = 1'b0;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// N-channel debouncer: shared sample prescaler plus one debounce_channel per input.
// Define MULTI_DEBOUNCER_LONG_PRESS_EN to enable the per-channel HOLD long-press flags.
module multi_debouncer
   import multi_debouncer_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int TICK_DIV   = 100000,
   parameter int STABLE_CNT = 16,
   parameter int CNT_W      = 5,
   parameter int LONG_CNT   = 1000
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [N_CH-1:0]   IN,
   output logic [N_CH-1:0]   OUT,
   output logic [N_CH-1:0]   RISE,
   output logic [N_CH-1:0]   FALL,
   output logic [2*N_CH-1:0] STATEVAL,
   output logic              TICK,
   output logic [N_CH-1:0]   HOLD
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   if (!cnt_w_ok(CNT_W, STABLE_CNT)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for STABLE_CNT, or STABLE_CNT below 2");
   end
   if ((N_CH < 1) || (N_CH > 16) || (TICK_DIV < 1)) begin : g_bad_params
      $error("N_CH must be 1..16 and TICK_DIV at least 1");
   end

   logic [PRE_W-1:0] presc_q;
   logic [PRE_W-1:0] presc_d;
   logic             tick_q;

   always_comb begin
      presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
   end

   // tick_q is high exactly while presc_q sits at its last count; TICK_DIV=1 holds it high.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= (presc_d == PRE_LAST);
      end
   end

   assign TICK = tick_q;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      debounce_channel #(
         .STABLE_CNT (STABLE_CNT),
         .CNT_W      (CNT_W),
         .LONG_CNT   (LONG_CNT)
      ) u_ch (
         .clk_i   (CLK),
         .rst_ni  (RESET),
         .tick_i  (tick_q),
         .in_i    (IN[gi]),
         .out_o   (OUT[gi]),
         .rise_o  (RISE[gi]),
         .fall_o  (FALL[gi]),
         .state_o (STATEVAL[2*gi +: 2]),
         .hold_o  (HOLD[gi])
      );
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: vector table, directed corner cases, random stimulus vs. run-length model.
module tb_multi_debouncer;

   localparam int N      = 4;
   localparam int TDIV   = 4;
   localparam int STABLE = 4;
   localparam int LONG   = 10;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   in_s;
   logic [N-1:0]   out_s, rise_s, fall_s, hold_s;
   logic [2*N-1:0] sv_s;
   logic           tick_s;

   multi_debouncer #(
      .N_CH(N), .TICK_DIV(TDIV), .STABLE_CNT(STABLE), .CNT_W(3), .LONG_CNT(LONG)
   ) dut (
      .CLK(clk), .RESET(rst_n), .IN(in_s), .OUT(out_s), .RISE(rise_s),
      .FALL(fall_s), .STATEVAL(sv_s), .TICK(tick_s), .HOLD(hold_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit mon_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: a channel flips its level once STABLE consecutive tick samples disagree with it.
   int           m_cyc;
   logic         m_tick;
   logic [N-1:0] m_p0, m_p1, m_out, m_rise, m_fall, m_hold;
   int           m_run  [N];
   int           m_hcnt [N];

   always @(posedge clk or negedge rst_n) begin
      logic s;
      logic was_ih;
      if (!rst_n) begin
         m_cyc = 0; m_tick = 1'b0;
         m_p0 = '0; m_p1 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_hold = '0;
         for (int i = 0; i < N; i++) begin m_run[i] = 0; m_hcnt[i] = 0; end
      end else begin
         for (int i = 0; i < N; i++) begin
            s = m_p1[i];
            was_ih = m_out[i] && (m_run[i] == 0);
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (m_tick) begin
               if (s != m_out[i]) begin
                  m_run[i]++;
                  if (m_run[i] == STABLE) begin
                     m_out[i] = s;
                     m_run[i] = 0;
                     if (s) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
            if (m_out[i] && m_run[i] == 0) begin
               if (m_tick && was_ih && m_hcnt[i] < LONG) m_hcnt[i]++;
            end else begin
               m_hcnt[i] = 0;
            end
            m_hold[i] = (m_hcnt[i] >= LONG);
`else
            m_hold[i] = 1'b0 & was_ih;
`endif
         end
         m_p1 = m_p0;
         m_p0 = in_s;
         m_cyc = (m_cyc + 1) % TDIV;
         m_tick = (m_cyc == TDIV - 1);
      end
   end

   function automatic logic [63:0] model_vec();
      logic [2*N-1:0] sv;
      for (int i = 0; i < N; i++) sv[2*i +: 2] = {m_out[i], m_run[i] != 0};
      return 64'({m_out, m_rise, m_fall, sv, m_tick, m_hold});
   endfunction

   always @(negedge clk) begin
      if (mon_en) check("cycle_vs_model", 64'({out_s, rise_s, fall_s, sv_s, tick_s, hold_s}), model_vec());
   end

   typedef struct {
      logic [N-1:0]   in;
      int             hold;
      logic [N-1:0]   exp_out;
      logic [2*N-1:0] exp_sv;
   } vec_t;
   vec_t tbl [6];

   initial begin
      int k, lat, cnt_a, cnt_b;
      logic [N-1:0] rise_at, others;
      logic rise_after, seen3, dropped, bounced_hi;

      tbl[0] = '{4'b0000, 20, 4'b0000, 8'h00};
      tbl[1] = '{4'b0001, 40, 4'b0001, 8'h02};
      tbl[2] = '{4'b0110, 40, 4'b0110, 8'h28};
      tbl[3] = '{4'b1111, 40, 4'b1111, 8'hAA};
      tbl[4] = '{4'b0000, 40, 4'b0000, 8'h00};
      tbl[5] = '{4'b1010, 40, 4'b1010, 8'h88};

      rst_n = 1'b0;
      in_s  = '0;
      repeat (3) @(negedge clk);
      check("reset_state", 64'({out_s, rise_s, fall_s, sv_s, tick_s, hold_s}), 64'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Prescaler phase after release, then period.
      k = 0;
      while (tick_s !== 1'b1 && k < 12) begin @(negedge clk); k++; end
      check("first_tick_delay", 64'(k), 64'd3);
      k = 0;
      do begin @(negedge clk); k++; end while (tick_s !== 1'b1 && k < 12);
      check("tick_period", 64'(k), 64'(TDIV));

      for (int i = 0; i < 6; i++) begin
         in_s = tbl[i].in;
         repeat (tbl[i].hold) @(negedge clk);
         $display("vector %0d: in=%b out=%b sv=%h", i, in_s, out_s, sv_s);
         check($sformatf("table_out_%0d", i), 64'(out_s), 64'(tbl[i].exp_out));
         check($sformatf("table_sv_%0d", i), 64'(sv_s), 64'(tbl[i].exp_sv));
      end

      // Clean press on channel 0, launched right after a tick.
      in_s = '0;
      repeat (40) @(negedge clk);
      k = 0;
      while (tick_s !== 1'b1 && k < 8) begin @(negedge clk); k++; end
      in_s = 4'b0001;
      lat = 0; rise_at = '0; others = '0; rise_after = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 5) check("press_wait_hi_state", 64'(sv_s[1:0]), 64'd1);
         if (lat != 0 && c == lat + 1) rise_after = rise_s[0];
         if (out_s[0] && lat == 0) begin lat = c; rise_at = rise_s; others = out_s[3:1]; end
      end
      $display("clean press: latency=%0d rise=%b", lat, rise_at);
      check("press_latency", 64'(lat), 64'd17);
      check("press_rise_pulse", 64'(rise_at), 64'b0001);
      check("press_rise_one_cycle", 64'(rise_after), 64'd0);
      check("press_other_channels", 64'(others), 64'd0);

      // Release glitch on channel 2: two low ticks must not drop OUT[2].
      in_s = 4'b0101;
      repeat (40) @(negedge clk);
      seen3 = 1'b0; dropped = 1'b0; cnt_a = 0;
      for (int c = 0; c < 40; c++) begin
         if (c == 0) in_s[2] = 1'b0;
         if (c == 8) in_s[2] = 1'b1;
         @(negedge clk);
         if (sv_s[5:4] == 2'd3) seen3 = 1'b1;
         if (!out_s[2]) dropped = 1'b1;
         if (fall_s[2]) cnt_a++;
      end
      $display("release glitch: seen_wait_lo=%0d dropped=%0d falls=%0d", seen3, dropped, cnt_a);
      check("glitch_saw_wait_lo", 64'(seen3), 64'd1);
      check("glitch_out_held", 64'(dropped), 64'd0);
      check("glitch_no_fall", 64'(cnt_a), 64'd0);
      check("glitch_back_idle_hi", 64'(sv_s[5:4]), 64'd2);

      // Bounce on channel 1: toggle every 3 cycles, then settle high.
      in_s = 4'b0001;
      bounced_hi = 1'b0; cnt_a = 0; cnt_b = 0;
      for (int c = 0; c < 90; c++) begin
         if (c > 0 && c % 3 == 0) in_s[1] = ~in_s[1];
         @(negedge clk);
         if (out_s[1]) bounced_hi = 1'b1;
         if (rise_s[1]) cnt_a++;
      end
      in_s[1] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (rise_s[1]) cnt_b++;
      end
      $display("bounce: out_during=%0d rises_during=%0d rises_after=%0d", bounced_hi, cnt_a, cnt_b);
      check("bounce_out_low", 64'(bounced_hi), 64'd0);
      check("bounce_no_rise", 64'(cnt_a), 64'd0);
      check("bounce_single_rise", 64'(cnt_b), 64'd1);
      check("bounce_final_out", 64'(out_s[1]), 64'd1);

      // All four channels rise together.
      in_s = '0;
      repeat (40) @(negedge clk);
      in_s = 4'b1111;
      k = 0;
      do begin @(negedge clk); k++; end while (rise_s == '0 && k < 40);
      $display("simultaneous: rise=%b after %0d cycles", rise_s, k);
      check("simultaneous_rise", 64'(rise_s), 64'hF);

      // Asynchronous reset in the middle of WAIT_HI on channel 3.
      in_s = '0;
      repeat (40) @(negedge clk);
      in_s = 4'b1000;
      repeat (7) @(negedge clk);
      check("mid_wait_state", 64'(sv_s[7:6]), 64'd1);
      #2 rst_n = 1'b0;
      #1 check("async_reset", 64'({out_s, rise_s, fall_s, sv_s, tick_s, hold_s}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      in_s  = '0;
      cnt_a = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (rise_s != '0 || fall_s != '0) cnt_a++;
      end
      check("post_reset_no_pulse", 64'(cnt_a), 64'd0);
      check("post_reset_state", 64'(sv_s), 64'd0);

      // Random per-channel toggling against the model.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) in_s[i] = ~in_s[i];
      end
      @(negedge clk);
      mon_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised N-channel successor to the single-input debouncer, for push-buttons and switches on the board.
- An internal prescaler produces a sample-enable tick, so the block runs on one clock only; no divided clock is used.
- Each channel has its own 2-flop synchroniser, a 4-state FSM and a stability counter.
- Outputs per channel: a debounced level, one-cycle RISE/FALL pulses and FSM state, for the top-level controller and the display.

Parameters:
- N_CH, 4, number of independent input channels (1..16).
- TICK_DIV, 100000, CLK cycles per sample tick (1 = tick every cycle).
- STABLE_CNT, 16, consecutive agreeing samples needed to change OUT (>=2).
- CNT_W, 5, stability counter width; must satisfy 2**CNT_W > STABLE_CNT.
- LONG_CNT, 1000, ticks of continuous high OUT before HOLD asserts (used only with the optional feature).

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-low reset.
- IN  input  N_CH  raw bouncy inputs, asynchronous to CLK.
- OUT  output  N_CH  debounced levels.
- RISE  output  N_CH  one-CLK pulse when OUT[i] goes 0->1.
- FALL  output  N_CH  one-CLK pulse when OUT[i] goes 1->0.
- STATEVAL  output  2*N_CH  FSM state of channel i at bits [2i+1:2i].
- TICK  output  1  sample tick, for debug.
- HOLD  output  N_CH  long-press flags.

Behaviour:
- Reset (RESET=0, async assert, sync release): all of the following clear to 0.
  - Prescaler, synchronisers, counters.
  - OUT, RISE, FALL, TICK, HOLD.
  - Every FSM to IDLE_LO (STATEVAL all 0).
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - TICK=1 for exactly one cycle when count==TICK_DIV-1.
  - TICK_DIV=1 gives TICK held high.
- Synchroniser: IN[i] passes two flops to give s[i]; the FSM sees s[i] only on TICK cycles.
- FSM states (encoding): IDLE_LO=0, WAIT_HI=1, IDLE_HI=2, WAIT_LO=3. No transition occurs without TICK.
- IDLE_LO: s=1 -> WAIT_HI, cnt=1; s=0 -> stay.
- WAIT_HI:
  - s=0 -> IDLE_LO, cnt=0.
  - s=1 and cnt==STABLE_CNT-1 -> IDLE_HI, cnt=0, OUT=1, RISE=1 next cycle.
  - Otherwise cnt++.
- IDLE_HI: s=0 -> WAIT_LO, cnt=1; s=1 -> stay.
- WAIT_LO: mirror of WAIT_HI. On completion -> IDLE_LO, OUT=0, FALL=1.
- Latency: OUT changes on the cycle after the TICK carrying the STABLE_CNT-th consecutive agreeing sample, plus 2 synchroniser cycles.
- Glitch rejection: any disagreeing sample aborts the WAIT state back to its IDLE state. OUT never toggles on a bounce shorter than STABLE_CNT ticks.
- RISE/FALL: registered, high for exactly one CLK, never both high on the same channel in the same cycle.
- Counter: never exceeds STABLE_CNT-1, so no wrap occurs.
- Channels are fully independent. Simultaneous transitions on several channels are all reported in the same cycle.
- Reset mid-WAIT: counter discarded, state returns to IDLE_LO, no pulse emitted.

Optional Feature:
- Macro: MULTI_DEBOUNCER_LONG_PRESS_EN.
- With the macro defined, each channel has a saturating hold counter:
  - Counts TICKs while in IDLE_HI.
  - HOLD[i]=1 once the count reaches LONG_CNT and stays high while in IDLE_HI.
  - Counter and HOLD clear on leaving IDLE_HI or on reset.
  - Counter width is $clog2(LONG_CNT+1).
- Without the macro: HOLD is tied to 0 and no hold counters are synthesised.

Decomposition:
- Package multi_debouncer_pkg holds:
  - the 2-bit state typedef;
  - constants ST_IDLE_LO/ST_WAIT_HI/ST_IDLE_HI/ST_WAIT_LO;
  - a width-check function used in an elaboration assertion on CNT_W.
- Sub-module debounce_channel (synchroniser, FSM, counter, optional hold logic) is instantiated N_CH times in a generate loop. The prescaler lives in the top level.

Test Plan:
- Run with TICK_DIV=4, STABLE_CNT=4, N_CH=4.
- Reset: hold RESET=0 mid-sequence -> all outputs 0 and STATEVAL=0 immediately (async); TICK period is 4 CLKs after release.
- Clean press: IN[0] 0->1 held -> STATEVAL[1:0]=1 after first tick; OUT[0]=1 and one-cycle RISE[0] after the 4th high tick (~16+2 CLK); other channels unchanged.
- Bounce: toggle IN[1] every 3 CLK for 90 CLK, then hold 1 -> OUT[1] stays 0 during bouncing, rises exactly once after 4 stable ticks, single RISE pulse.
- Release glitch: from OUT[2]=1, drop IN[2] for 2 ticks then restore -> STATEVAL goes 3 then back to 2; OUT[2] stays 1, no FALL pulse.
- Simultaneous: IN[3:0] 0->F together -> RISE=4'hF in the same cycle.
- Long press (macro defined, LONG_CNT=10): hold IN[0] high -> HOLD[0]=1 after 10 ticks in IDLE_HI; clears when OUT[0] falls. Macro undefined -> HOLD stays 0.
